// File: rtl/fifo_monarchy.sv
`default_nettype none
// ============================================================================
// Module     : fifo_monarchy
// Description: Single-clock FIFO for one TLP data lane. The occupancy counter
//              drives all status flags. Define FIFO_ERROR_EN to enable the
//              sticky overflow/underflow flag.
// Revision   : 1.0 - initial release
// ============================================================================
module fifo_monarchy #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_TH      = 2,
  parameter int AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_error
);

  localparam int                 c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AF_TH     = (ADDR_WIDTH + 1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] c_AE_TH     = (ADDR_WIDTH + 1)'(AE_TH);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] c_CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic [ADDR_WIDTH:0]   w_free;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign full         = (r_count == c_DEPTH_CNT);
  assign empty        = (r_count == '0);
  assign w_free       = c_DEPTH_CNT - r_count;
  assign almost_full  = (w_free <= c_AF_TH);
  assign almost_empty = (r_count <= c_AE_TH);
  assign count        = r_count;
  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERROR_EN
  logic r_fifo_error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fifo_error <= 1'b0;
    end else if ((push && !w_push_ok) || (pop && !w_pop_ok)) begin
      r_fifo_error <= 1'b1;
    end
  end

  assign fifo_error = r_fifo_error;
`else
  assign fifo_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_monarchy.sv
`default_nettype none
// ============================================================================
// Module     : tb_fifo_monarchy
// Description: Directed vector table plus randomized queue-model run for
//              fifo_monarchy (DEPTH=8, AF_TH=2, AE_TH=2).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fifo_monarchy;

  localparam int c_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic [9:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       fifo_error;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_monarchy #(
    .DATA_WIDTH(10),
    .ADDR_WIDTH(3),
    .AF_TH     (2),
    .AE_TH     (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .fifo_error  (fifo_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_n;
    bit         push;
    bit         pop;
    logic [9:0] din;
    int         cnt;
    bit         vld;
    logic [9:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit p, bit q, logic [9:0] d, int c, bit v, logic [9:0] o);
    vec_t x;
    x.rst_n = r; x.push = p; x.pop = q; x.din = d;
    x.cnt = c; x.vld = v; x.dout = o;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flag expectations come straight from the occupancy definitions.
  task automatic chk_state(string tag, int cnt, bit vld, logic [9:0] dout, bit err);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".full"}, 32'(full), 32'(cnt == c_DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'((c_DEPTH - cnt) <= 2));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(vld));
    if (vld) chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
    chk({tag, ".fifo_error"}, 32'(fifo_error), 32'(err));
  endtask

  function automatic bit err_en();
`ifdef FIFO_ERROR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int         prev_cnt;
    bit         err_m;
    bit         push_ok;
    bit         pop_ok;
    logic [9:0] q[$];
    logic [9:0] exp_dout;
    bit         exp_vld;
    int         bias;

    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

    // 1: reset then idle
    add(0, 0, 0, 10'h000, 0, 0, 10'h000);
    add(1, 0, 0, 10'h000, 0, 0, 10'h000);
    // 2: fill with 0x001..0x008
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 10'(i), i, 0, 10'h000);
    // 3: overflow attempt while full
    add(1, 1, 0, 10'h3FF, 8, 0, 10'h000);
    // 4: push+pop while full, new words 0x101..0x108 replace the old ones
    for (int i = 0; i < 8; i++) add(1, 1, 1, 10'(16'h101 + i), 8, 1, 10'(i + 1));
    // drain, proving the simultaneous pushes landed in order
    for (int i = 0; i < 8; i++) add(1, 0, 1, 10'h000, 7 - i, 1, 10'(16'h101 + i));
    add(1, 0, 1, 10'h000, 0, 0, 10'h108);
    // 5: push+pop on empty is push-only
    add(1, 1, 1, 10'h055, 1, 0, 10'h108);
    add(1, 0, 1, 10'h000, 0, 1, 10'h055);
    // 6: partial fill, reset, pop on the now-empty FIFO
    for (int i = 0; i < 5; i++) add(1, 1, 0, 10'(16'h0A0 + i), i + 1, 0, 10'h055);
    add(0, 0, 0, 10'h000, 0, 0, 10'h000);
    add(1, 0, 1, 10'h000, 0, 0, 10'h000);

    prev_cnt = 0;
    err_m    = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n; push = vecs[i].push;
      pop = vecs[i].pop; data_in = vecs[i].din;
      if (!vecs[i].rst_n) err_m = 1'b0;
      else if ((vecs[i].push && !vecs[i].pop && prev_cnt == c_DEPTH) ||
               (vecs[i].pop && prev_cnt == 0)) err_m = 1'b1;
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].dout, err_m & err_en());
      if (!vecs[i].vld) chk($sformatf("vec%0d.data_out_hold", i), 32'(data_out), 32'(vecs[i].dout));
      prev_cnt = vecs[i].cnt;
    end

    // Randomized run against a queue model.
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    q.delete(); err_m = 1'b0; exp_dout = '0; exp_vld = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bias    = ((cyc / 40) % 2 == 0) ? 75 : 25;
      reset   = ($urandom_range(0, 99) != 0);
      push    = ($urandom_range(0, 99) < bias);
      pop     = ($urandom_range(0, 99) < (100 - bias));
      data_in = 10'($urandom);
      if (!reset) begin
        q.delete(); err_m = 1'b0; exp_dout = '0; exp_vld = 1'b0;
      end else begin
        pop_ok  = pop && (q.size() > 0);
        push_ok = push && (q.size() < c_DEPTH || pop);
        if ((push && !push_ok) || (pop && !pop_ok)) err_m = 1'b1;
        exp_vld = pop_ok;
        if (pop_ok) exp_dout = q.pop_front();
        if (push_ok) q.push_back(data_in);
      end
      @(posedge clk); #1;
      chk_state($sformatf("rnd%0d", cyc), q.size(), exp_vld, exp_dout, err_m & err_en());
      chk($sformatf("rnd%0d.data_out_reg", cyc), 32'(data_out), 32'(exp_dout));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
